// File: rtl/sw_pkg.sv
// Shared Smith-Waterman definitions: nucleotide codes, loader states, ASCII encoder.
// Pure declarations and functions; no latency, no flow control.
package sw_pkg;

  localparam logic [1:0] _A = 2'b10;
  localparam logic [1:0] _G = 2'b11;
  localparam logic [1:0] _T = 2'b00;
  localparam logic [1:0] _C = 2'b01;

  typedef enum logic [1:0] {
    Q_LOAD   = 2'd0,
    T_STREAM = 2'd1,
    DRAIN    = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Returns {valid, code}; unknown characters fall back to _T with valid low.
  function automatic logic [2:0] encode_base(input logic [7:0] ascii);
    logic [7:0] up;
    up = (ascii >= 8'h61 && ascii <= 8'h7a) ? ascii - 8'h20 : ascii;
    case (up)
      8'h41:   encode_base = {1'b1, _A};
      8'h47:   encode_base = {1'b1, _G};
      8'h54:   encode_base = {1'b1, _T};
      8'h43:   encode_base = {1'b1, _C};
      default: encode_base = {1'b0, _T};
    endcase
  endfunction

  // Number of bits needed to hold the value itself (log2b(128) = 8).
  function automatic int log2b(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((value >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sw_seq_loader_if.sv
// Character stream into the loader: valid/ready handshake with frame delimiter.
// Carries no state; a transfer happens on any edge with s_valid && s_ready.
interface sw_seq_loader_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_char;
  logic       s_last;

  modport master (output s_valid, output s_char, output s_last, input s_ready);
  modport slave  (input s_valid, input s_char, input s_last, output s_ready);
endinterface

// File: rtl/sw_base_encoder.sv
// Combinational ASCII nucleotide to 2-bit code plus valid flag (case-insensitive).
// Zero latency, no flow control.
module sw_base_encoder
  import sw_pkg::*;
(
  input  logic [7:0] ascii,
  output logic [1:0] code,
  output logic       valid
);

  assign {valid, code} = encode_base(ascii);

endmodule

// File: rtl/sw_seq_loader.sv
// Packs a query frame onto the array's query bus, then streams target bases and waits for drain.
// Target bases emerge one cycle after acceptance; s_ready drops during drain/done and in reset.
module sw_seq_loader
  import sw_pkg::*;
#(
  parameter int LENGTH     = 128,
  parameter int LOG_LENGTH = log2b(LENGTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  sw_seq_loader_if.slave          s,
  output logic [2*LENGTH-1:0]     query,
  output logic [LOG_LENGTH-1:0]   query_len,
  output logic                    en_out,
  output logic [1:0]              data_out,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow,
  output logic                    bad_char
);

  localparam logic [LOG_LENGTH:0]   LEN_Q = (LOG_LENGTH+1)'(LENGTH);
  localparam logic [LOG_LENGTH:0]   ONE_Q = (LOG_LENGTH+1)'(1);
  localparam logic [LOG_LENGTH-1:0] LEN_L = LOG_LENGTH'(LENGTH);
  localparam logic [LOG_LENGTH-1:0] ONE_L = LOG_LENGTH'(1);

  state_t              state, state_n;
  logic [LOG_LENGTH:0] qcnt;
  logic [LOG_LENGTH:0] drain_cnt;
  logic [1:0]          code;
  logic                code_vld;
  logic                ready;
  logic                xfer;
  logic                room;

  sw_base_encoder u_enc (
    .ascii (s.s_char),
    .code  (code),
    .valid (code_vld)
  );

  assign ready     = !rst && (state == Q_LOAD || state == T_STREAM);
  assign s.s_ready = ready;
  assign xfer      = s.s_valid && ready;
  assign room      = qcnt < LEN_Q;
  assign busy      = state != Q_LOAD;
  assign done      = state == DONE;

  always_comb begin
    state_n = state;
    case (state)
      Q_LOAD:   if (xfer && s.s_last) state_n = T_STREAM;
      T_STREAM: if (xfer && s.s_last) state_n = DRAIN;
      // Leave as the count reaches zero so done lands query_len+1 cycles after the last base.
      DRAIN:    if (drain_cnt <= ONE_Q) state_n = DONE;
      DONE:     state_n = Q_LOAD;
      default:  state_n = Q_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= Q_LOAD;
      query     <= '0;
      query_len <= '0;
      qcnt      <= '0;
      drain_cnt <= '0;
      en_out    <= 1'b0;
      data_out  <= 2'b00;
      overflow  <= 1'b0;
      bad_char  <= 1'b0;
    end else begin
      state  <= state_n;
      en_out <= 1'b0;
      case (state)
        Q_LOAD: begin
          if (xfer) begin
            // A new query frame wipes the previous query and sticky flags.
            if (qcnt == '0) begin
              query    <= '0;
              overflow <= 1'b0;
              bad_char <= 1'b0;
            end
            if (!code_vld) bad_char <= 1'b1;
            if (room) query[2*qcnt[LOG_LENGTH-1:0] +: 2] <= code;
            else      overflow <= 1'b1;
            if (s.s_last) begin
              query_len <= room ? qcnt[LOG_LENGTH-1:0] + ONE_L : LEN_L;
              qcnt      <= '0;
            end else if (room) begin
              qcnt <= qcnt + ONE_Q;
            end
          end
        end
        T_STREAM: begin
          if (xfer) begin
            en_out   <= 1'b1;
            data_out <= code;
            if (!code_vld) bad_char <= 1'b1;
            if (s.s_last) drain_cnt <= {1'b0, query_len} + ONE_Q;
          end
        end
        DRAIN: begin
          if (drain_cnt != '0) drain_cnt <= drain_cnt - ONE_Q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_seq_loader.sv
// Directed plus randomized bench for sw_seq_loader against a string-level reference model.
module tb_sw_seq_loader;

  localparam int LENGTH     = 128;
  localparam int LOG_LENGTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sw_seq_loader_if sif();

  logic [2*LENGTH-1:0]   query;
  logic [LOG_LENGTH-1:0] query_len;
  logic                  en_out;
  logic [1:0]            data_out;
  logic                  busy, done, overflow, bad_char;

  sw_seq_loader #(.LENGTH(LENGTH), .LOG_LENGTH(LOG_LENGTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .s         (sif.slave),
    .query     (query),
    .query_len (query_len),
    .en_out    (en_out),
    .data_out  (data_out),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .bad_char  (bad_char)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int both_err = 0;
  int en_cyc[$];
  logic [1:0] en_dat[$];
  int done_cyc[$];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and log what the array side saw this cycle.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (en_out === 1'b1) begin
      en_cyc.push_back(cyc);
      en_dat.push_back(data_out);
      if (done === 1'b1) both_err++;
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
  endtask

  function automatic logic [1:0] model_code(input byte c);
    case (c)
      "A", "a": return 2'b10;
      "G", "g": return 2'b11;
      "C", "c": return 2'b01;
      default:  return 2'b00;
    endcase
  endfunction

  function automatic bit model_bad(input byte c);
    return !(c inside {"A", "a", "C", "c", "G", "g", "T", "t"});
  endfunction

  task automatic send(input string str, input int gap, input bit with_last);
    for (int i = 0; i < str.len(); i++) begin
      int w;
      w = 0;
      sif.s_valid = 1'b1;
      sif.s_char  = str[i];
      sif.s_last  = with_last && (i == str.len() - 1);
      #1;
      while (sif.s_ready !== 1'b1 && w < 300) begin
        step();
        #1;
        w++;
      end
      if (w >= 300) chk("accept_timeout", 256'(w), 256'(0));
      step();
      sif.s_valid = 1'b0;
      sif.s_last  = 1'b0;
      if (i != str.len() - 1) repeat (gap) step();
    end
  endtask

  task automatic run_job(input string tag, input string qs, input string ts, input int gap, input bit offer);
    logic [255:0] eq;
    logic [63:0]  ed, od;
    int n, qlen, rdy_hi, w;
    bit qbad, tbad;
    eq = '0; ed = '0; od = '0; qbad = 0; tbad = 0;
    n = qs.len();
    qlen = (n > LENGTH) ? LENGTH : n;
    for (int k = 0; k < n; k++) begin
      qbad |= model_bad(qs[k]);
      if (k < LENGTH) eq[2*k +: 2] = model_code(qs[k]);
    end
    for (int k = 0; k < ts.len(); k++) begin
      tbad |= model_bad(ts[k]);
      ed[2*k +: 2] = model_code(ts[k]);
    end
    en_cyc.delete(); en_dat.delete(); done_cyc.delete();

    send(qs, 0, 1'b1);
    chk({tag, "/query"}, 256'(query), eq);
    chk({tag, "/query_len"}, 256'(query_len), 256'(qlen));
    chk({tag, "/overflow"}, 256'(overflow), 256'(n > LENGTH));
    chk({tag, "/bad_q"}, 256'(bad_char), 256'(qbad));
    chk({tag, "/busy_t"}, 256'(busy), 256'(1));

    send(ts, gap, 1'b1);
    rdy_hi = 0; w = 0;
    sif.s_valid = offer; sif.s_char = "G"; sif.s_last = 1'b1;
    while (done_cyc.size() == 0 && w < 400) begin
      #1;
      if (sif.s_ready === 1'b1) rdy_hi++;
      step();
      w++;
    end
    #1;
    if (sif.s_ready === 1'b1) rdy_hi++;
    sif.s_valid = 1'b0; sif.s_last = 1'b0;
    if (offer) chk({tag, "/rdy_drain"}, 256'(rdy_hi), 256'(0));
    repeat (3) step();

    for (int i = 0; i < en_dat.size() && i < 32; i++) od[2*i +: 2] = en_dat[i];
    chk({tag, "/en_count"}, 256'(en_dat.size()), 256'(ts.len()));
    chk({tag, "/data_seq"}, 256'(od), 256'(ed));
    for (int i = 1; i < en_cyc.size(); i++)
      chk({tag, "/en_spacing"}, 256'(en_cyc[i] - en_cyc[i-1]), 256'(gap + 1));
    chk({tag, "/done_count"}, 256'(done_cyc.size()), 256'(1));
    if (done_cyc.size() > 0 && en_cyc.size() > 0)
      chk({tag, "/done_delay"}, 256'(done_cyc[0] - en_cyc[en_cyc.size()-1]), 256'(qlen + 1));
    chk({tag, "/bad_t"}, 256'(bad_char), 256'(qbad | tbad));
    chk({tag, "/busy_idle"}, 256'(busy), 256'(0));
    chk({tag, "/query_hold"}, 256'(query), eq);
    chk({tag, "/len_hold"}, 256'(query_len), 256'(qlen));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    string c130, pool, rq, rt;
    int rg;

    // Reset and idle
    rst = 1'b1;
    sif.s_valid = 1'b1; sif.s_char = "A"; sif.s_last = 1'b0;
    #1;
    chk("rst/ready0", 256'(sif.s_ready), 256'(0));
    step();
    chk("rst/ready1", 256'(sif.s_ready), 256'(0));
    step();
    chk("rst/query", 256'(query), 256'(0));
    chk("rst/outs", 256'({query_len, en_out, data_out, busy, done, overflow, bad_char}), 256'(0));
    rst = 1'b0;
    sif.s_valid = 1'b0;
    #1;
    chk("idle/ready", 256'(sif.s_ready), 256'(1));
    chk("idle/busy", 256'(busy), 256'(0));
    step();

    // Basic run
    run_job("basic", "ACGT", "GA", 0, 1'b0);
    chk("basic/q_lit", 256'(query[7:0]), 256'(8'b00_11_01_10));
    if (done_cyc.size() > 0 && en_cyc.size() > 0)
      chk("basic/done5", 256'(done_cyc[0] - en_cyc[en_cyc.size()-1]), 256'(5));

    // Bubbles and lower case
    run_job("bubble", "ACGT", "aCg", 1, 1'b0);

    // Overflow, then a one-character frame clears it
    c130 = "";
    for (int i = 0; i < 130; i++) c130 = {c130, "C"};
    run_job("ovf", c130, "T", 0, 1'b0);
    run_job("ovf_clr", "T", "A", 0, 1'b0);

    // Bad character and back-pressure during drain
    run_job("badpress", "ACGTAC", "ANA", 0, 1'b1);

    // Reset in the middle of a target frame
    en_cyc.delete(); en_dat.delete(); done_cyc.delete();
    send("ACG", 0, 1'b1);
    send("GAT", 0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst/busy", 256'(busy), 256'(0));
    chk("mid_rst/len", 256'(query_len), 256'(0));
    chk("mid_rst/en", 256'(en_out), 256'(0));
    done_cyc.delete();
    repeat (10) step();
    chk("mid_rst/no_done", 256'(done_cyc.size()), 256'(0));

    // Randomized frames
    pool = "ACGTacgtAGCTNx";
    for (int j = 0; j < 6; j++) begin
      int ql, tl;
      rq = ""; rt = "";
      ql = $urandom_range(1, 24);
      tl = $urandom_range(1, 16);
      for (int k = 0; k < ql; k++) begin
        int p;
        p = $urandom_range(0, 13);
        rq = {rq, pool.substr(p, p)};
      end
      for (int k = 0; k < tl; k++) begin
        int p;
        p = $urandom_range(0, 13);
        rt = {rt, pool.substr(p, p)};
      end
      rg = $urandom_range(0, 2);
      run_job($sformatf("rand%0d", j), rq, rt, rg, j[0]);
    end

    chk("done_vs_en", 256'(both_err), 256'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
